// File: rtl/spi_xfer_arbiter.sv
// Round-robin owner selection for a shared SPI master engine: latches the winner's
// divisor/mode, strobes send_data, tracks tip/receive_data and returns done (or a timeout).
module spi_xfer_arbiter #(
  parameter int NREQ = 4,
  parameter int DIVW = 12,
  parameter int TOUT = 4096
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DIVW-1:0] req_div,
  input  logic [2*NREQ-1:0]    req_mode,
  input  logic                 spiswai,
  input  logic                 tip,
  input  logic                 receive_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 timeout_err,
  output logic                 busy,
  output logic                 mstr,
  output logic                 send_data,
  output logic [1:0]           spi_mode,
  output logic [DIVW-1:0]      BaudRateDivisor
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TOUT);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_TIP, XFER, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   tout_cnt;
  logic [1:0]      rst_q;
  logic            rst;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            tout_last;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) rst_q <= 2'b11;
    else        rst_q <= {rst_q[0], 1'b0};
  end
  assign rst = rst_q[1];

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s -= NREQ;
    return IW'(s);
  endfunction

  // First requester at or after rr_ptr, scanning with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && req[wrap_add(rr_ptr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  assign tout_last = (tout_cnt == CW'(TOUT - 1));

  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      tout_cnt        <= '0;
      grant           <= '0;
      done            <= '0;
      timeout_err     <= 1'b0;
      busy            <= 1'b0;
      mstr            <= 1'b0;
      send_data       <= 1'b0;
      spi_mode        <= '0;
      BaudRateDivisor <= '0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      send_data   <= 1'b0;
      case (state)
        IDLE: begin
          if (!spiswai && pick_vld) begin
            state           <= LOAD;
            owner           <= pick_idx;
            grant           <= NREQ'(1) << pick_idx;
            mstr            <= 1'b1;
            busy            <= 1'b1;
            spi_mode        <= req_mode[2*pick_idx +: 2];
            BaudRateDivisor <= req_div[DIVW*pick_idx +: DIVW];
          end
        end
        LOAD: begin
          state     <= START;
          send_data <= 1'b1;
        end
        START: begin
          state    <= WAIT_TIP;
          tout_cnt <= '0;
        end
        WAIT_TIP: begin
          // A frame short enough to finish before tip is seen still completes normally.
          if (receive_data && !tip) begin
            state <= DONE;
            done  <= grant;
          end else if (tout_last) begin
            state       <= DONE;
            done        <= grant;
            timeout_err <= 1'b1;
          end else begin
            tout_cnt <= tout_cnt + CW'(1);
            if (tip) state <= XFER;
          end
        end
        XFER: begin
          // End-of-frame wins over a coincident timeout.
          if (receive_data) begin
            state <= DONE;
            done  <= grant;
          end else if (tout_last) begin
            state       <= DONE;
            done        <= grant;
            timeout_err <= 1'b1;
          end else begin
            tout_cnt <= tout_cnt + CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          grant  <= '0;
          mstr   <= 1'b0;
          busy   <= 1'b0;
          rr_ptr <= wrap_add(owner, 1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboarded bench: the driver predicts each transfer's owner/config/outcome from
// round-robin rules; a monitor checks every done pulse against the queue.
module tb_spi_xfer_arbiter;

  localparam int NREQ = 4;
  localparam int DIVW = 12;
  localparam int TOUT = 64;

  logic                 PCLK = 1'b0;
  logic                 PRESET;
  logic [NREQ-1:0]      req;
  logic [NREQ*DIVW-1:0] req_div;
  logic [2*NREQ-1:0]    req_mode;
  logic                 spiswai, tip, receive_data;
  logic [NREQ-1:0]      grant, done;
  logic                 timeout_err, busy, mstr, send_data;
  logic [1:0]           spi_mode;
  logic [DIVW-1:0]      BaudRateDivisor;

  spi_xfer_arbiter #(.NREQ(NREQ), .DIVW(DIVW), .TOUT(TOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_div(req_div), .req_mode(req_mode),
    .spiswai(spiswai), .tip(tip), .receive_data(receive_data), .grant(grant), .done(done),
    .timeout_err(timeout_err), .busy(busy), .mstr(mstr), .send_data(send_data),
    .spi_mode(spi_mode), .BaudRateDivisor(BaudRateDivisor)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int         owner;
    logic [11:0] div;
    logic [1:0] mode;
    logic       tout;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = 0;

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected one within bound", name);
  endtask

  // Round-robin model: first set request at or after the pointer, modulo NREQ.
  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (model_ptr + k) % NREQ;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic issue(input logic [3:0] r, input logic tout);
    exp_t e;
    e.owner   = model_pick(r);
    e.div     = req_div[e.owner*DIVW +: DIVW];
    e.mode    = req_mode[e.owner*2 +: 2];
    e.tout    = tout;
    model_ptr = (e.owner + 1) % NREQ;
    q.push_back(e);
  endtask

  task automatic wait_send();
    int n = 0;
    while (!send_data && n < 200) begin tick(); n++; end
    if (!send_data) bound_fail("wait_send");
  endtask

  task automatic wait_done();
    int n = 0;
    while (done == '0 && n < 200) begin tick(); n++; end
    if (done == '0) bound_fail("wait_done");
  endtask

  // Called at the negedge of the send_data cycle. 0=normal, 1=short frame, 2=no tip.
  task automatic respond(input int kind);
    int d1, d2;
    if (kind == 0) begin
      d1 = $urandom_range(0, 10);
      d2 = $urandom_range(2, 20);
      repeat (d1) tick();
      tip = 1'b1;
      repeat (d2) tick();
      receive_data = 1'b1;
      tick();
      receive_data = 1'b0;
      tip = 1'b0;
    end else if (kind == 1) begin
      d1 = $urandom_range(1, 10);
      repeat (d1) tick();
      receive_data = 1'b1;
      tick();
      receive_data = 1'b0;
    end
  endtask

  // Monitor: every done pulse must match the oldest predicted transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (done != '0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_done: got done=%b expected none", done);
        end else begin
          e = q.pop_front();
          chk("sb_done", 32'(done), 32'(1) << e.owner);
          chk("sb_grant", 32'(grant), 32'(1) << e.owner);
          chk("sb_tout", 32'(timeout_err), 32'(e.tout));
          chk("sb_div", 32'(BaudRateDivisor), 32'(e.div));
          chk("sb_mode", 32'(spi_mode), 32'(e.mode));
        end
      end
    end
  end

  initial begin
    int   n;
    bit   any;
    logic [3:0] r;
    int   kind;

    PRESET = 1'b1; req = '0; req_div = '0; req_mode = '0;
    spiswai = 1'b0; tip = 1'b0; receive_data = 1'b0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flags", {28'd0, timeout_err, busy, mstr, send_data}, 0);
    chk("rst_cfg", {18'd0, spi_mode, BaudRateDivisor}, 0);
    PRESET = 1'b0;
    repeat (4) tick();

    // Fairness: all requesting, grants rotate from requester 0.
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      issue(4'b1111, 1'b0);
      wait_send();
      chk("fair_grant", 32'(grant), 32'(1) << (i % 4));
      respond(0);
      wait_done();
    end
    req = '0;
    repeat (2) tick();

    // Single transfer with exact latency.
    req_div[1*DIVW +: DIVW] = 12'd10;
    req_mode[2 +: 2] = 2'b01;
    req = 4'b0010;
    issue(4'b0010, 1'b0);
    tick();
    chk("single_grant", 32'(grant), 32'b0010);
    chk("single_mstr_busy", {30'd0, mstr, busy}, 3);
    chk("single_send_early", 32'(send_data), 0);
    chk("single_div", 32'(BaudRateDivisor), 10);
    chk("single_mode", 32'(spi_mode), 1);
    tick();
    chk("single_send", 32'(send_data), 1);
    tick();
    chk("single_send_1cyc", 32'(send_data), 0);
    tip = 1'b1;
    repeat (3) tick();
    receive_data = 1'b1;
    tick();
    chk("single_done", 32'(done), 32'b0010);
    receive_data = 1'b0; tip = 1'b0; req = '0;
    tick();
    chk("single_done_1cyc", 32'(done), 0);
    chk("single_idle", {28'd0, grant}, 0);
    chk("single_idle_flags", {30'd0, mstr, busy}, 0);

    // Timeout: tip never comes; TOUT cycles in WAIT_TIP after the strobe cycle, then DONE.
    req = 4'b0001;
    issue(4'b0001, 1'b1);
    wait_send();
    n = 0;
    while (done == '0 && n < 200) begin tick(); n++; end
    chk("tout_latency", n, TOUT + 1);
    chk("tout_err", 32'(timeout_err), 1);
    req = '0;
    tick();
    chk("tout_idle", 32'(busy), 0);

    // End-of-frame coincident with the last allowed cycle completes normally.
    req = 4'b0001;
    issue(4'b0001, 1'b0);
    wait_send();
    tip = 1'b1;
    repeat (TOUT) tick();
    chk("bound_not_early", 32'(done), 0);
    receive_data = 1'b1;
    tick();
    chk("bound_done", 32'(done), 32'b0001);
    chk("bound_no_err", 32'(timeout_err), 0);
    receive_data = 1'b0; tip = 1'b0; req = '0;
    tick();

    // Wait mode blocks new grants but not an in-flight transfer.
    spiswai = 1'b1;
    req = 4'b0001;
    any = 1'b0;
    repeat (100) begin tick(); if (grant != '0) any = 1'b1; end
    chk("swai_block", 32'(any), 0);
    spiswai = 1'b0;
    issue(4'b0001, 1'b0);
    tick();
    chk("swai_release_grant", 32'(grant), 32'b0001);
    wait_send();
    tip = 1'b1;
    repeat (2) tick();
    spiswai = 1'b1;
    tick();
    receive_data = 1'b1;
    tick();
    receive_data = 1'b0; tip = 1'b0;
    wait_done();
    any = 1'b0;
    repeat (20) begin tick(); if (grant != '0) any = 1'b1; end
    chk("swai_hold_after", 32'(any), 0);
    req = '0; spiswai = 1'b0;
    tick();

    // Reset mid-transfer: outputs drop immediately, no done, pointer back to 0.
    req = 4'b0100;
    wait_send();
    tip = 1'b1;
    repeat (3) tick();
    #2 PRESET = 1'b1;
    #1;
    chk("rstmid_grant", 32'(grant), 0);
    chk("rstmid_flags", {29'd0, mstr, busy, send_data}, 0);
    tick();
    PRESET = 1'b0; tip = 1'b0; req = '0;
    model_ptr = 0;
    repeat (4) tick();
    req = 4'b1010;
    issue(4'b1010, 1'b0);
    tick();
    chk("rstmid_rearb", 32'(grant), 32'b0010);
    wait_send();
    respond(0);
    wait_done();

    // Config stability: divisor change mid-transfer applies only to the next one.
    req_div[3*DIVW +: DIVW] = 12'h123;
    req_mode[6 +: 2] = 2'b10;
    req = 4'b1000;
    issue(4'b1000, 1'b0);
    wait_send();
    tip = 1'b1;
    repeat (2) tick();
    req_div[3*DIVW +: DIVW] = 12'h456;
    req_mode[6 +: 2] = 2'b11;
    tick();
    chk("cfg_hold_div", 32'(BaudRateDivisor), 32'h123);
    chk("cfg_hold_mode", 32'(spi_mode), 2);
    receive_data = 1'b1;
    tick();
    chk("cfg_done_div", 32'(BaudRateDivisor), 32'h123);
    receive_data = 1'b0; tip = 1'b0;
    issue(4'b1000, 1'b0);
    wait_send();
    chk("cfg_new_div", 32'(BaudRateDivisor), 32'h456);
    respond(1);
    wait_done();

    // Randomized requests, configs and responses.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        req_div[k*DIVW +: DIVW] = DIVW'($urandom);
        req_mode[k*2 +: 2] = 2'($urandom);
      end
      r = 4'($urandom_range(1, 15));
      kind = $urandom_range(0, 2);
      req = r;
      issue(r, kind == 2);
      wait_send();
      respond(kind);
      wait_done();
    end
    req = '0;
    repeat (5) tick();
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
